instr_fetch: RTL and testbench

//  IF stage: producer of the 32-bit instruction words consumed by the ID-stage control decoder.

---
 rtl/instr_fetch_pkg.sv | 12 +
 rtl/instr_fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 81 ++++++++
 tb/tb_instr_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the IF stage.
package instr_fetch_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: DEPTH entries of {instr, pc}, flush has priority over push.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           wr, rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign head  = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  // Storage needs no reset; count/pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC owner, single-outstanding IMEM reads, buffered {instr, pc, pc+4} to ID.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc, tag_pc, last_pc, last_pc4, head_pc4;
  logic          inflight, pop, issue, push, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  head, push_data;

  assign pop       = id_valid & id_ready;
  // Slots committed after this edge: buffered + returning - leaving.
  assign occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = (occ < (CW+1)'(DEPTH)) & (~full | pop) & ~redirect & ~rst;
  assign imem_req  = issue;
  assign imem_addr = pc;
  assign push      = inflight & ~redirect;
  assign push_data = '{instr: imem_rdata, pc: tag_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign head_pc4 = head.pc + 32'd4;
  assign id_valid = ~empty;
  assign id_instr = empty ? INSTR_NOP : head.instr;
  assign id_pc    = empty ? last_pc   : head.pc;
  assign id_pc4   = empty ? last_pc4  : head_pc4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      last_pc  <= '0;
      last_pc4 <= '0;
    end else begin
      inflight <= issue;
      if (redirect) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        pc     <= pc + 32'd4;
        tag_pc <= pc;
      end
      // Shadow of the head so id_pc/id_pc4 hold while the buffer is empty.
      if (!empty) begin
        last_pc  <= head.pc;
        last_pc4 <= head_pc4;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with an in-order PC-stream scoreboard.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr, id_pc, id_pc4;

  int errs = 0;
  int checks = 0;
  int pops = 0;

  instr_fetch #(.RESET_PC(32'h0000_3000), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  // Synchronous IMEM; garbage on cycles without a request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memw(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ID must see an unbroken +4 stream restarting at each redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc, last_pc, last_pc4;

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      gen_pc   = 32'h0000_3000;
      last_pc  = 32'h0;
      last_pc4 = 32'h0;
    end else begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
      if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (id_valid) begin
        e = exp_q[0];
        chk("head_pc", id_pc, e);
        chk("head_instr", id_instr, memw(e));
        chk("head_pc4", id_pc4, e + 32'd4);
        last_pc  = e;
        last_pc4 = e + 32'd4;
        if (id_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end else begin
        chk("empty_nop", id_instr, INSTR_NOP);
        chk("empty_pc_hold", id_pc, last_pc);
        chk("empty_pc4_hold", id_pc4, last_pc4);
      end
      if (redirect) begin
        chk("no_req_on_redirect", {31'b0, imem_req}, 32'h0);
        exp_q.delete();
        gen_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    redirect = 1'b0;
    #1;
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (id_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    do_reset();
    // cycle 0: first request of RESET_PC
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    @(posedge clk); #2;
    chk("cyc1_valid", {31'b0, id_valid}, 32'h0);
    @(posedge clk); #2;
    chk("cyc2_valid", {31'b0, id_valid}, 32'h1);
    chk("cyc2_pc", id_pc, 32'h0000_3000);
    @(posedge clk); #2;
    chk("cyc3_pc", id_pc, 32'h0000_3004);
    @(posedge clk); #1;
    chk("stall_head", id_pc, 32'h0000_3008);
    id_ready = 1'b0;
    #1 chk("stall_req0", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("stall_pc", id_pc, 32'h0000_3008);
      chk("stall_valid", {31'b0, id_valid}, 32'h1);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    id_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3043;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_valid(10);
    chk("redir_target", id_pc, 32'h0000_3040);
    // redirect coinciding with a pop, landing at the top of the address space
    wait_valid(10);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_valid(10);
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc4, 32'h0000_0000);
    @(posedge clk); #2;
    chk("wrap_next_valid", {31'b0, id_valid}, 32'h1);
    chk("wrap_next_pc", id_pc, 32'h0000_0000);
    // back-to-back redirects, second one while empty with nothing in flight
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_4000;
    @(posedge clk); #1;
    redirect_pc = 32'h0000_5001;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("b2b_empty", {31'b0, id_valid}, 32'h0);
    wait_valid(10);
    chk("b2b_target", id_pc, 32'h0000_5000);
    repeat (3) @(posedge clk);
    do_reset();
    wait_valid(10);
    chk("restart_pc", id_pc, 32'h0000_3000);
    // random phase
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                : $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    id_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("progress", {31'b0, (pops > 500)}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
